// File: rtl/ram_refresh_sched.sv
// rtl/ram_refresh_sched.sv - DRAM refresh obligation scheduler with saturating backlog
//
// Ports:
//   CLK        system clock, all state updates on rising edge
//   Reset      synchronous active-high reset
//   En         refresh timer enable (low freezes new ticks only)
//   RefAck     DRAM controller refresh-in-progress level
//   RefReq     backlog nonzero, refresh may be done opportunistically
//   RefUrgent  backlog or age demands a refresh at next opportunity
//   PendCnt    current backlog of owed refreshes
//   Overflow   sticky, a tick arrived while backlog was saturated
module ram_refresh_sched #(
    parameter int REF_PERIOD    = 375,
    parameter int PEND_MAX      = 7,
    parameter int URGENT_THRESH = 2,
    parameter int URGENT_AGE    = 240
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       En,
    input  logic       RefAck,
    output logic       RefReq,
    output logic       RefUrgent,
    output logic [2:0] PendCnt,
    output logic       Overflow
);

    localparam logic [11:0] PERIOD_LAST = 12'(REF_PERIOD - 1);
    localparam logic [2:0]  PEND_SAT    = 3'(PEND_MAX);
    localparam logic [2:0]  THRESH      = 3'(URGENT_THRESH);
    localparam logic [9:0]  AGE_LIMIT   = 10'(URGENT_AGE);

    logic [11:0] timerCnt;
    logic [9:0]  ageCnt;
    logic        ackQ;

    logic        tick;
    logic        ackEdge;
    logic [11:0] timerNext;
    logic [2:0]  pendNext;
    logic [9:0]  ageNext;
    logic        ovfNext;

    always_comb begin
        tick      = En && (timerCnt == PERIOD_LAST);
        // A refresh cycle is retired once, on the rising edge of the ack level.
        ackEdge   = RefAck && !ackQ;

        timerNext = timerCnt;
        if (En) begin
            timerNext = (timerCnt == PERIOD_LAST) ? 12'd0 : timerCnt + 12'd1;
        end

        pendNext = PendCnt;
        ovfNext  = Overflow;
        if (tick && ackEdge) begin
            pendNext = PendCnt;
        end else if (tick) begin
            if (PendCnt == PEND_SAT) begin
                ovfNext = 1'b1;
            end else begin
                pendNext = PendCnt + 3'd1;
            end
        end else if (ackEdge) begin
            // A spurious ack with nothing owed is silently ignored.
            if (PendCnt != 3'd0) begin
                pendNext = PendCnt - 3'd1;
            end
        end

        // Age follows the backlog as it stood before this edge, so it starts
        // counting on the cycle after RefReq rises.
        ageNext = ageCnt;
        if (ackEdge || (PendCnt == 3'd0)) begin
            ageNext = 10'd0;
        end else if (ageCnt != 10'h3FF) begin
            ageNext = ageCnt + 10'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            timerCnt  <= 12'd0;
            ageCnt    <= 10'd0;
            ackQ      <= 1'b0;
            PendCnt   <= 3'd0;
            RefReq    <= 1'b0;
            RefUrgent <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            timerCnt  <= timerNext;
            ageCnt    <= ageNext;
            ackQ      <= RefAck;
            PendCnt   <= pendNext;
            Overflow  <= ovfNext;
            RefReq    <= (pendNext != 3'd0);
            RefUrgent <= (pendNext >= THRESH) || (ageNext >= AGE_LIMIT);
        end
    end

endmodule

// File: tb/tb_ram_refresh_sched.sv
// tb/tb_ram_refresh_sched.sv - directed self-checking bench for ram_refresh_sched
module tb_ram_refresh_sched;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       En;
    logic       RefAck;
    logic       RefReq;
    logic       RefUrgent;
    logic [2:0] PendCnt;
    logic       Overflow;

    int checkCnt = 0;
    int failCnt  = 0;

    ram_refresh_sched #(
        .REF_PERIOD    (375),
        .PEND_MAX      (7),
        .URGENT_THRESH (2),
        .URGENT_AGE    (240)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .En        (En),
        .RefAck    (RefAck),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .PendCnt   (PendCnt),
        .Overflow  (Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checkCnt++;
        if (obs != exp) begin
            failCnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input int req, input int urg, input int pend, input int ovf);
        checkVal($sformatf("%s.RefReq", tag), int'(RefReq), req);
        checkVal($sformatf("%s.RefUrgent", tag), int'(RefUrgent), urg);
        checkVal($sformatf("%s.PendCnt", tag), int'(PendCnt), pend);
        checkVal($sformatf("%s.Overflow", tag), int'(Overflow), ovf);
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic ackPulse(input int len);
        RefAck = 1'b1;
        step(len);
        RefAck = 1'b0;
        step(1);
    endtask

    initial begin
        Reset  = 1'b1;
        En     = 1'b1;
        RefAck = 1'b0;
        step(2);
        Reset = 1'b0;
        checkOut("reset", 0, 0, 0, 0);

        // First tick on the 375th enabled edge.
        step(374);
        checkOut("preTick1", 0, 0, 0, 0);
        step(1);
        checkOut("tick1", 1, 0, 1, 0);

        // Age-driven urgency exactly 240 cycles after RefReq rose.
        step(239);
        checkOut("age239", 1, 0, 1, 0);
        step(1);
        checkOut("age240", 1, 1, 1, 0);

        // Second tick at edge 750: backlog 2, threshold urgency.
        step(134);
        checkOut("preTick2", 1, 1, 1, 0);
        step(1);
        checkOut("tick2", 1, 1, 2, 0);

        // Six-cycle ack retires exactly one refresh and clears age.
        RefAck = 1'b1;
        step(1);
        checkOut("ackEdge", 1, 0, 1, 0);
        step(5);
        checkOut("ackHeld", 1, 0, 1, 0);
        RefAck = 1'b0;
        step(1);
        checkOut("ackFall", 1, 0, 1, 0);

        // Saturation and sticky overflow.
        doReset();
        step(375 * 7);
        checkOut("sat7", 1, 1, 7, 0);
        step(375);
        checkOut("ovf", 1, 1, 7, 1);
        for (int i = 0; i < 7; i++) ackPulse(1);
        checkOut("drained", 0, 0, 0, 1);
        doReset();
        checkOut("ovfReset", 0, 0, 0, 0);

        // Ack edge coincident with a tick at backlog 3.
        step(375 * 3);
        checkOut("pend3", 1, 1, 3, 0);
        step(374);
        RefAck = 1'b1;
        step(1);
        checkOut("coincident", 1, 1, 3, 0);
        RefAck = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) ackPulse(1);
        checkOut("drain3", 0, 0, 0, 0);
        ackPulse(2);
        checkOut("spurious", 0, 0, 0, 0);

        // Enable freeze mid-period.
        doReset();
        step(200);
        En = 1'b0;
        step(1000);
        checkOut("frozen", 0, 0, 0, 0);
        En = 1'b1;
        step(174);
        checkOut("preResume", 0, 0, 0, 0);
        step(1);
        checkOut("resumeTick", 1, 0, 1, 0);
        step(375);
        checkOut("resumeTick2", 1, 1, 2, 0);

        // Reset while ack is high, then ack falls with no effect.
        RefAck = 1'b1;
        step(1);
        checkOut("ackBeforeRst", 1, 0, 1, 0);
        Reset = 1'b1;
        step(1);
        checkOut("rstMidAck", 0, 0, 0, 0);
        Reset = 1'b0;
        step(2);
        RefAck = 1'b0;
        step(1);
        checkOut("ackFallAfterRst", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
